// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin client arbiter onto a one-command-at-a-time DDR3 backend with refresh priority and timeout
module mem_port_arbiter #(
  parameter int NPORTS = 3,
  parameter int AW = 22,
  parameter int DW = 8,
  parameter int BW = 16,
  parameter int TIMEOUT = 255,
  localparam int LW = (BW / DW > 1) ? $clog2(BW / DW) : 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [NPORTS-1:0]    req,
  input  logic [NPORTS-1:0]    we,
  input  logic [NPORTS*AW-1:0] addr,
  input  logic [NPORTS*DW-1:0] din,
  output logic [NPORTS-1:0]    ack,
  output logic [DW-1:0]        dout,
  input  logic                 refresh,
  output logic                 ready,
  output logic                 timeout_err,
  output logic                 mem_cmd_rd,
  output logic                 mem_cmd_wr,
  output logic                 mem_cmd_ref,
  output logic [AW-1:0]        mem_addr,
  output logic [BW-1:0]        mem_din,
  input  logic                 mem_busy,
  input  logic [BW-1:0]        mem_dout,
  input  logic                 mem_data_ready,
  input  logic [LW-1:0]        lane_sel
);
  localparam int PW = NPORTS > 1 ? $clog2(NPORTS) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {INIT, IDLE, WAIT} state_t;
  state_t state_q, state_d;
  logic init_cnt_q, init_cnt_d;
  logic ready_q, ready_d;
  logic err_q, err_d;
  logic [NPORTS-1:0] ack_q, ack_d;
  logic [DW-1:0] dout_q, dout_d;
  logic rd_q, rd_d, wr_q, wr_d, ref_q, ref_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [BW-1:0] mem_din_q, mem_din_d;
  logic pend_q, pend_d;
  logic [PW-1:0] ptr_q, ptr_d, gnt_q, gnt_d;
  logic we_q, we_d, is_ref_q, is_ref_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NPORTS-1:0] req_eff;
  logic [PW:0] idx;
  logic found;
  logic [PW-1:0] g, nxt;
  logic [DW-1:0] dsel, lane_data;
  logic done;
  always_comb begin
    req_eff = req & ~ack_q;
    idx = '0;
    found = 1'b0;
    g = '0;
    for (int k = 0; k < NPORTS; k++) begin
      idx = (PW + 1)'(ptr_q) + (PW + 1)'(k);
      idx = idx >= (PW + 1)'(NPORTS) ? idx - (PW + 1)'(NPORTS) : idx;
      if (!found && req_eff[idx[PW-1:0]]) begin
        found = 1'b1;
        g = idx[PW-1:0];
      end
    end
    nxt = g == PW'(NPORTS - 1) ? '0 : g + 1'b1;
    dsel = DW'(din >> (int'(g) * DW));
    lane_data = DW'(mem_dout >> (DW * (int'(lane_sel) % (BW / DW))));
    done = cnt_q >= CW'(3) && !mem_busy;
    state_d = state_q;
    init_cnt_d = init_cnt_q;
    ready_d = ready_q;
    err_d = err_q;
    ack_d = '0;
    dout_d = dout_q;
    rd_d = 1'b0;
    wr_d = 1'b0;
    ref_d = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_din_d = mem_din_q;
    pend_d = pend_q | refresh;
    ptr_d = ptr_q;
    gnt_d = gnt_q;
    we_d = we_q;
    is_ref_d = is_ref_q;
    cnt_d = cnt_q;
    unique case (state_q)
      INIT: begin
        init_cnt_d = !mem_busy;
        if (!mem_busy && init_cnt_q) begin
          ready_d = 1'b1;
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (!mem_busy && (pend_q || refresh)) begin
          ref_d = 1'b1;
          pend_d = 1'b0;
          is_ref_d = 1'b1;
          cnt_d = CW'(1);
          state_d = WAIT;
        end else if (!mem_busy && found) begin
          gnt_d = g;
          we_d = we[g];
          wr_d = we[g];
          rd_d = !we[g];
          mem_addr_d = AW'(addr >> (int'(g) * AW));
          mem_din_d = {(BW / DW){dsel}};
          is_ref_d = 1'b0;
          ptr_d = nxt;
          cnt_d = CW'(1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (done || cnt_q == CW'(TIMEOUT)) begin
          state_d = IDLE;
          ack_d = is_ref_q ? '0 : NPORTS'(1) << gnt_q;
          dout_d = (is_ref_q || we_q) ? dout_q : done ? lane_data : '0;
          err_d = err_q || !done || (!is_ref_q && !we_q && !mem_data_ready);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = INIT;
    endcase
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= INIT;
      init_cnt_q <= 1'b0;
      ready_q <= 1'b0;
      err_q <= 1'b0;
      ack_q <= '0;
      dout_q <= '0;
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      ref_q <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q <= '0;
      pend_q <= 1'b0;
      ptr_q <= '0;
      gnt_q <= '0;
      we_q <= 1'b0;
      is_ref_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      init_cnt_q <= init_cnt_d;
      ready_q <= ready_d;
      err_q <= err_d;
      ack_q <= ack_d;
      dout_q <= dout_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      ref_q <= ref_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q <= mem_din_d;
      pend_q <= pend_d;
      ptr_q <= ptr_d;
      gnt_q <= gnt_d;
      we_q <= we_d;
      is_ref_q <= is_ref_d;
      cnt_q <= cnt_d;
    end
  end
  assign ack = ack_q;
  assign dout = dout_q;
  assign ready = ready_q;
  assign timeout_err = err_q;
  assign mem_cmd_rd = rd_q;
  assign mem_cmd_wr = wr_q;
  assign mem_cmd_ref = ref_q;
  assign mem_addr = mem_addr_q;
  assign mem_din = mem_din_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench with a simple busy-latency backend model
module tb_mem_port_arbiter;
  localparam int NP = 3;
  localparam int AW = 22;
  localparam int DW = 8;
  localparam int BW = 16;
  localparam int TO = 255;
  localparam int LAT = 3;
  logic clk = 1'b0;
  logic resetn;
  logic [NP-1:0] req, we, ack;
  logic [NP*AW-1:0] addr;
  logic [NP*DW-1:0] din;
  logic [DW-1:0] dout;
  logic refresh, ready, timeout_err;
  logic mem_cmd_rd, mem_cmd_wr, mem_cmd_ref;
  logic [AW-1:0] mem_addr;
  logic [BW-1:0] mem_din, mem_dout;
  logic mem_busy, mem_data_ready;
  logic [0:0] lane_sel;
  logic init_hold, hang;
  int bcnt = 0;
  typedef struct {int kind; logic [AW-1:0] a; logic [BW-1:0] d;} cmd_t;
  typedef struct {int port; bit rd; logic [DW-1:0] d;} ack_t;
  cmd_t cmd_exp[$];
  ack_t ack_exp[$];
  cmd_t mc;
  ack_t ma;
  int n_checks = 0;
  int n_errors = 0;
  always #5 clk = ~clk;
  mem_port_arbiter #(.NPORTS(NP), .AW(AW), .DW(DW), .BW(BW), .TIMEOUT(TO)) dut (
    .clk(clk), .resetn(resetn), .req(req), .we(we), .addr(addr), .din(din),
    .ack(ack), .dout(dout), .refresh(refresh), .ready(ready), .timeout_err(timeout_err),
    .mem_cmd_rd(mem_cmd_rd), .mem_cmd_wr(mem_cmd_wr), .mem_cmd_ref(mem_cmd_ref),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_busy(mem_busy), .mem_dout(mem_dout),
    .mem_data_ready(mem_data_ready), .lane_sel(lane_sel)
  );
  assign mem_busy = init_hold | hang | (bcnt != 0);
  always @(posedge clk) bcnt <= (mem_cmd_rd | mem_cmd_wr | mem_cmd_ref) ? LAT : (bcnt > 0 ? bcnt - 1 : 0);
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic exp_cmd(input int kind, input logic [AW-1:0] a, input logic [BW-1:0] d);
    cmd_t c;
    c.kind = kind;
    c.a = a;
    c.d = d;
    cmd_exp.push_back(c);
  endtask
  task automatic exp_ack(input int p, input bit rd, input logic [DW-1:0] d);
    ack_t x;
    x.port = p;
    x.rd = rd;
    x.d = d;
    ack_exp.push_back(x);
  endtask
  task automatic set_port(input int p, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    we[p] = w;
    addr[p*AW +: AW] = a;
    din[p*DW +: DW] = d;
  endtask
  task automatic wait_ack(input int p, input string tag);
    int k;
    for (k = 0; k < 600; k++) begin
      @(negedge clk);
      if (ack[p]) break;
    end
    if (k == 600) check(tag, 0, 1);
    req[p] = 1'b0;
  endtask
  task automatic wait_ready();
    int k;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ready) break;
    end
    if (k == 20) check("ready_timeout", 0, 1);
  endtask
  task automatic do_reset();
    resetn = 1'b0;
    init_hold = 1'b1;
    hang = 1'b0;
    req = '0;
    refresh = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (10) @(negedge clk);
    init_hold = 1'b0;
    wait_ready();
  endtask
  always @(negedge clk) begin
    if (mem_cmd_rd | mem_cmd_wr | mem_cmd_ref) begin
      check("cmd_onehot", $onehot({mem_cmd_rd, mem_cmd_wr, mem_cmd_ref}), 1);
      if (cmd_exp.size() == 0) begin
        check("cmd_unexpected", {mem_cmd_ref, mem_cmd_wr, mem_cmd_rd}, 0);
      end else begin
        mc = cmd_exp.pop_front();
        check("cmd_kind", mem_cmd_ref ? 2 : mem_cmd_wr ? 1 : 0, mc.kind);
        if (mc.kind != 2) check("cmd_addr", mem_addr, mc.a);
        if (mc.kind == 1) check("cmd_din", mem_din, mc.d);
      end
    end
    if (ack != 0) begin
      check("ack_onehot", $onehot0(ack), 1);
      if (ack_exp.size() == 0) begin
        check("ack_unexpected", ack, 0);
      end else begin
        ma = ack_exp.pop_front();
        check("ack_port", ack, 64'd1 << ma.port);
        if (ma.rd) check("ack_dout", dout, ma.d);
      end
    end
  end
  initial begin
    int n, acks, c, k;
    resetn = 1'b0;
    init_hold = 1'b1;
    hang = 1'b0;
    req = '0;
    we = '0;
    addr = '0;
    din = '0;
    refresh = 1'b0;
    mem_dout = '0;
    mem_data_ready = 1'b1;
    lane_sel = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ack", ack, 0);
    check("rst_dout", dout, 0);
    check("rst_ready", ready, 0);
    check("rst_err", timeout_err, 0);
    check("rst_cmd", {mem_cmd_rd, mem_cmd_wr, mem_cmd_ref}, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_din", mem_din, 0);
    resetn = 1'b1;
    set_port(0, 1'b0, 22'h000123, 8'h00);
    req[0] = 1'b1;
    repeat (45) @(negedge clk);
    check("init_not_ready", ready, 0);
    req[0] = 1'b0;
    repeat (5) @(negedge clk);
    init_hold = 1'b0;
    @(negedge clk);
    check("ready_edge1", ready, 0);
    @(negedge clk);
    check("ready_edge2", ready, 1);
    set_port(1, 1'b1, 22'h380010, 8'hA5);
    exp_cmd(1, 22'h380010, 16'hA5A5);
    exp_ack(1, 1'b0, 8'h00);
    req[1] = 1'b1;
    wait_ack(1, "wr_ack_timeout");
    mem_dout = 16'h12C3;
    set_port(0, 1'b0, 22'h000040, 8'h00);
    lane_sel = 1'b0;
    exp_cmd(0, 22'h000040, 16'h0);
    exp_ack(0, 1'b1, 8'hC3);
    req[0] = 1'b1;
    wait_ack(0, "rd0_ack_timeout");
    repeat (2) @(negedge clk);
    check("dout_hold", dout, 8'hC3);
    lane_sel = 1'b1;
    exp_cmd(0, 22'h000040, 16'h0);
    exp_ack(0, 1'b1, 8'h12);
    req[0] = 1'b1;
    wait_ack(0, "rd1_ack_timeout");
    set_port(2, 1'b0, 22'h2ABCDE, 8'h00);
    exp_cmd(0, 22'h2ABCDE, 16'h0);
    req[2] = 1'b1;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (mem_cmd_rd) break;
    end
    if (k == 50) check("abort_cmd_timeout", 0, 1);
    @(negedge clk);
    #2;
    resetn = 1'b0;
    init_hold = 1'b1;
    req = '0;
    #1;
    check("abort_ack", ack, 0);
    check("abort_dout", dout, 0);
    check("abort_ready", ready, 0);
    check("abort_cmd", {mem_cmd_rd, mem_cmd_wr, mem_cmd_ref}, 0);
    check("abort_addr", mem_addr, 0);
    check("abort_din", mem_din, 0);
    do_reset();
    set_port(0, 1'b1, 22'h000100, 8'h11);
    set_port(1, 1'b1, 22'h380010, 8'hA5);
    set_port(2, 1'b1, 22'h1FFFFF, 8'h7E);
    exp_cmd(1, 22'h000100, 16'h1111);
    exp_cmd(1, 22'h380010, 16'hA5A5);
    exp_cmd(2, 22'h0, 16'h0);
    exp_cmd(1, 22'h1FFFFF, 16'h7E7E);
    exp_cmd(1, 22'h000100, 16'h1111);
    exp_cmd(1, 22'h380010, 16'hA5A5);
    exp_cmd(1, 22'h1FFFFF, 16'h7E7E);
    for (int i = 0; i < 6; i++) exp_ack(i % 3, 1'b0, 8'h00);
    req = 3'b111;
    n = 0;
    acks = 0;
    for (k = 0; k < 2000; k++) begin
      @(negedge clk);
      refresh = 1'b0;
      if (mem_cmd_rd | mem_cmd_wr | mem_cmd_ref) begin
        n++;
        if (n == 2) refresh = 1'b1;
      end
      if (ack != 0) acks++;
      if (acks == 6) begin
        req = '0;
        break;
      end
    end
    check("rot_acks", acks, 6);
    check("rot_err_clear", timeout_err, 0);
    mem_data_ready = 1'b0;
    mem_dout = 16'h5A3C;
    lane_sel = 1'b0;
    set_port(1, 1'b0, 22'h000777, 8'h00);
    exp_cmd(0, 22'h000777, 16'h0);
    exp_ack(1, 1'b1, 8'h3C);
    req[1] = 1'b1;
    wait_ack(1, "dr_ack_timeout");
    check("dr_err", timeout_err, 1);
    mem_data_ready = 1'b1;
    do_reset();
    check("rst_err_clear", timeout_err, 0);
    mem_dout = 16'hFFFF;
    set_port(0, 1'b0, 22'h001234, 8'h00);
    exp_cmd(0, 22'h001234, 16'h0);
    exp_ack(0, 1'b1, 8'hFF);
    req[0] = 1'b1;
    wait_ack(0, "pre_to_ack_timeout");
    exp_cmd(0, 22'h001234, 16'h0);
    exp_ack(0, 1'b1, 8'h00);
    req[0] = 1'b1;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (mem_cmd_rd) break;
    end
    if (k == 50) check("to_cmd_timeout", 0, 1);
    hang = 1'b1;
    c = 0;
    for (k = 0; k < 400; k++) begin
      @(negedge clk);
      c++;
      if (ack[0]) break;
    end
    req[0] = 1'b0;
    hang = 1'b0;
    check("to_cycles", c, TO);
    check("to_err", timeout_err, 1);
    repeat (10) @(negedge clk);
    check("to_sticky", timeout_err, 1);
    check("cmd_left", cmd_exp.size(), 0);
    check("ack_left", ack_exp.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
